// File: rtl/if_fetch_pkg.sv
// Shared CPU defines for the fetch stage: FSM encoding, the NOP word and the stall-vector bit names.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DROP  = 2'd2,
        FETCH_VALID = 2'd3
    } fetch_state_e;

    // Bit positions in the 6-bit pipeline stall vector; bit 0 freezes the PC.
    typedef enum int {
        STALL_PC  = 0,
        STALL_IF  = 1,
        STALL_ID  = 2,
        STALL_EX  = 3,
        STALL_MEM = 4,
        STALL_WB  = 5
    } stall_idx_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, PC-next mux and the imem request/drop FSM.
// Optional misaligned-fetch trap is enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic         flush,
    input  logic [31:0]  new_pc,
    input  logic         branch_flag,
    input  logic [31:0]  branch_target,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_inst,
    output logic         stallreq_if,
`ifdef IF_ALIGN_CHECK_EN
    output logic         if_excp,
`endif
    output fetch_state_e fetch_state_dbg
);

    // imem handshake: imem_req stays high with imem_addr frozen from the cycle it rises
    // until the cycle imem_ack is seen; imem_ack is a one-cycle strobe qualifying imem_rdata.
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  addr_q, addr_d;
    logic         new_req;
`ifdef IF_ALIGN_CHECK_EN
    logic         excp_q, excp_d;
`endif

    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            addr_q  <= word_align(RESET_PC);
`ifdef IF_ALIGN_CHECK_EN
            excp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
`ifdef IF_ALIGN_CHECK_EN
            excp_q  <= excp_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
`ifdef IF_ALIGN_CHECK_EN
        excp_d  = excp_q;
`endif
        unique case (state_q)
            FETCH_IDLE: begin
                if (flush) pc_d = new_pc;
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (flush) begin
                    // An unacked request must still complete, so its data is dropped later.
                    pc_d    = new_pc;
                    state_d = imem_ack ? FETCH_REQ : FETCH_DROP;
                end else if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = FETCH_VALID;
                end
            end
            FETCH_DROP: begin
                if (flush) pc_d = new_pc;
                if (imem_ack) state_d = FETCH_REQ;
            end
            FETCH_VALID: begin
                if (flush) begin
                    pc_d    = new_pc;
                    state_d = FETCH_REQ;
                end else if (!stall[STALL_PC]) begin
                    pc_d    = branch_flag ? branch_target : pc_q + 32'd4;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        // A fresh request starts whenever REQ is entered or re-entered after an ack.
        new_req = (state_d == FETCH_REQ) && ((state_q != FETCH_REQ) || imem_ack);
        if (new_req) addr_d = word_align(pc_d);

`ifdef IF_ALIGN_CHECK_EN
        if (new_req && (pc_d[1:0] != 2'b00)) begin
            state_d = FETCH_VALID;
            inst_d  = NOP_INST;
            addr_d  = addr_q;
            excp_d  = 1'b1;
        end else if ((state_q != FETCH_VALID) || (state_d != FETCH_VALID)) begin
            excp_d  = 1'b0;
        end
`endif
    end

    assign imem_req        = (state_q == FETCH_REQ) || (state_q == FETCH_DROP);
    assign imem_addr       = addr_q;
    assign if_pc           = pc_q;
    assign if_inst         = (state_q == FETCH_VALID) ? inst_q : NOP_INST;
    assign stallreq_if     = (state_q != FETCH_VALID);
    assign fetch_state_dbg = state_q;
`ifdef IF_ALIGN_CHECK_EN
    assign if_excp         = excp_q;
`endif

endmodule
